program_loader_ctrl: RTL



---
 rtl/loader_pkg.sv | 5 +
 rtl/byte_fifo.sv | 51 +++++
 rtl/program_loader_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot program loader.
package loader_pkg;
  typedef enum logic {S_LOAD, S_RUN} state_e;
  localparam logic [31:0] END_MARKER_DEF = 32'hffff_ffff;
endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO with a sticky overflow flag; a full FIFO accepts a push only alongside a pop.
module byte_fifo #(
  parameter int FIFO_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       overflow_o
);
  localparam int DEPTH = 1 << FIFO_LOG2;

  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_LOG2-1:0] wr_q, rd_q;
  logic [FIFO_LOG2:0]   cnt_q;
  logic                 ovf_q;
  logic                 pop_ok, push_ok;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = cnt_q[FIFO_LOG2];
  assign pop_ok     = pop_i & ~empty_o;
  assign push_ok    = push_i & (~full_o | pop_ok);
  assign dout_o     = empty_o ? 8'h00 : mem_q[rd_q];
  assign overflow_o = ovf_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + FIFO_LOG2'(1);
      if (pop_ok)  rd_q <= rd_q + FIFO_LOG2'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (FIFO_LOG2+1)'(1);
        2'b01:   cnt_q <= cnt_q - (FIFO_LOG2+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push_i && full_o && !pop_ok) ovf_q <= 1'b1;
    end
  end
endmodule

// File: rtl/program_loader_ctrl.sv
// Boot loader: assembles big-endian words from UART bytes into imem, then hands imem to the CPU.
// Define LOADER_CHECKSUM_EN to expose load_sum_o, the mod-2^32 sum of all written words.
module program_loader_ctrl
  import loader_pkg::*;
#(
  parameter int          IMEM_AW    = 14,
  parameter int          FIFO_LOG2  = 4,
  parameter logic [31:0] END_MARKER = END_MARKER_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  input  logic [IMEM_AW-1:0] cpu_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_wdata_o,
  output logic               imem_we_o,
  output logic               cpu_run_o,
  output logic [IMEM_AW:0]   load_count_o,
  output logic               load_overflow_o,
  output logic [7:0]         in_data_o,
  output logic               in_valid_o,
  input  logic               in_ready_i,
  output logic               in_overflow_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]        load_sum_o
`endif
);
  state_e           state_q;
  logic [31:0]      shift_q, wdata_q, word_d;
  logic [1:0]       idx_q;
  logic [IMEM_AW:0] load_count_q;
  logic             we_q, cpu_run_q, ovf_q;
  logic             fifo_empty, fifo_full;

  assign word_d = {shift_q[23:0], rx_data_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      shift_q      <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cpu_run_q    <= 1'b0;
      ovf_q        <= 1'b0;
      load_count_q <= '0;
    end else begin
      we_q <= 1'b0;
      // Count advances at the end of the write cycle so the write sees the pre-increment address.
      if (we_q) load_count_q <= load_count_q + (IMEM_AW+1)'(1);
      if (state_q == S_LOAD && rx_valid_i) begin
        shift_q <= word_d;
        idx_q   <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          if (word_d == END_MARKER) begin
            state_q   <= S_RUN;
            cpu_run_q <= 1'b1;
          end else if (load_count_q[IMEM_AW]) begin
            ovf_q <= 1'b1;
          end else begin
            we_q    <= 1'b1;
            wdata_q <= word_d;
          end
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  always_ff @(posedge clk) begin
    if (reset)     sum_q <= '0;
    else if (we_q) sum_q <= sum_q + wdata_q;
  end
  assign load_sum_o = sum_q;
`endif

  assign imem_addr_o     = (state_q == S_RUN) ? cpu_pc_i : load_count_q[IMEM_AW-1:0];
  assign imem_wdata_o    = wdata_q;
  assign imem_we_o       = we_q;
  assign cpu_run_o       = cpu_run_q;
  assign load_count_o    = load_count_q;
  assign load_overflow_o = ovf_q;
  assign in_valid_o      = ~fifo_empty;

  byte_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (rx_valid_i && state_q == S_RUN),
    .din_i     (rx_data_i),
    .pop_i     (in_ready_i),
    .dout_o    (in_data_o),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .overflow_o(in_overflow_o)
  );

  logic unused_full;
  assign unused_full = fifo_full;
endmodule
